// File: rtl/audio_frame_capture_if.sv
// Sample stream, frame handoff and frame bus for audio_frame_capture.
// master = upstream/downstream environment, slave = the capture block.
interface audio_frame_capture_if #(
    parameter int N = 100,
    parameter int W = 32
);
    logic             in_valid;
    logic [W-1:0]     in_sample;
    logic             in_ready;
    logic             frame_start;
    logic             frame_done;
    logic [N*W-1:0]   frame_data;
    logic [15:0]      frame_count;

    modport master (
        output in_valid, in_sample, frame_done,
        input  in_ready, frame_start, frame_data, frame_count
    );

    modport slave (
        input  in_valid, in_sample, frame_done,
        output in_ready, frame_start, frame_data, frame_count
    );
endinterface

// File: rtl/audio_frame_capture.sv
// Ping-pong frame capture: fills one N-sample bank while the other is frozen
// and presented to a downstream stage until that stage reports done.
module audio_frame_capture #(
    parameter int N = 100,
    parameter int W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    audio_frame_capture_if.slave  bus
);
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

    logic [W-1:0]     bank_mem [2][N];

    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic             wb_q, wb_d;
    logic             rd_bank_q, rd_bank_d;
    logic             full_q, full_d;
    logic             busy_q, busy_d;
    logic             frame_start_q, frame_start_d;
    logic [15:0]      frame_count_q, frame_count_d;

    logic             accept;
    logic             last_write;
    logic             handoff;

    always_comb begin
        accept        = bus.in_valid && !full_q;
        last_write    = accept && (wr_cnt_q == LAST_IDX);
        // A bank completing on this very edge can be handed off immediately.
        handoff       = (full_q || last_write) && !busy_q;

        wr_cnt_d      = wr_cnt_q;
        wb_d          = wb_q;
        rd_bank_d     = rd_bank_q;
        full_d        = full_q;
        busy_d        = busy_q;
        frame_start_d = 1'b0;
        frame_count_d = frame_count_q;

        if (accept) begin
            wr_cnt_d = last_write ? '0 : wr_cnt_q + CNT_W'(1);
        end
        if (last_write) begin
            full_d = 1'b1;
        end

        if (handoff) begin
            rd_bank_d     = wb_q;
            wb_d          = !wb_q;
            full_d        = 1'b0;
            busy_d        = 1'b1;
            frame_start_d = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
        end else if (busy_q && bus.frame_done) begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt_q      <= '0;
            wb_q          <= 1'b0;
            rd_bank_q     <= 1'b0;
            full_q        <= 1'b0;
            busy_q        <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            wr_cnt_q      <= wr_cnt_d;
            wb_q          <= wb_d;
            rd_bank_q     <= rd_bank_d;
            full_q        <= full_d;
            busy_q        <= busy_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
        end
    end

    // Bank storage is never cleared; only the write bank is ever written.
    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            bank_mem[wb_q][wr_cnt_q] <= bus.in_sample;
        end
    end

    assign bus.in_ready    = !full_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_count = frame_count_q;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_frame_out
            assign bus.frame_data[gi*W +: W] = bank_mem[rd_bank_q][gi];
        end
    endgenerate
endmodule

// File: tb/tb_audio_frame_capture.sv
// Directed bench for audio_frame_capture with a queue-based frame model.
module tb_audio_frame_capture;
    localparam int N = 100;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    audio_frame_capture_if #(.N(N), .W(W)) bus ();

    audio_frame_capture #(.N(N), .W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Model: samples of the frame being filled, the frozen frame, and status.
    logic [W-1:0] pend [$];
    logic [W-1:0] m_frame [N];
    bit           m_busy  = 1'b0;
    bit           m_valid = 1'b0;
    bit           m_start = 1'b0;
    logic [15:0]  m_count = 16'd0;
    int           start_pulses = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] slot(input int k);
        return bus.frame_data[k*W +: W];
    endfunction

    task automatic model_step();
        bit old_busy;
        bit handoff;
        if (reset) begin
            pend.delete();
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_start = 1'b0;
            m_count = 16'd0;
        end else begin
            old_busy = m_busy;
            if (bus.in_valid && pend.size() < N) pend.push_back(bus.in_sample);
            handoff = (pend.size() == N) && !old_busy;
            m_start = handoff;
            if (handoff) begin
                for (int k = 0; k < N; k++) m_frame[k] = pend[k];
                pend.delete();
                m_busy  = 1'b1;
                m_valid = 1'b1;
                m_count = m_count + 16'd1;
            end else if (old_busy && bus.frame_done) begin
                m_busy = 1'b0;
            end
        end
    endtask

    task automatic compare();
        logic [N*W-1:0] exp_vec;
        chk("in_ready", 64'(bus.in_ready), 64'(pend.size() < N));
        chk("frame_start", 64'(bus.frame_start), 64'(m_start));
        chk("frame_count", 64'(bus.frame_count), 64'(m_count));
        if (bus.frame_start === 1'b1) start_pulses++;
        if (m_valid) begin
            for (int k = 0; k < N; k++) exp_vec[k*W +: W] = m_frame[k];
            checks++;
            if (bus.frame_data !== exp_vec) begin
                failures++;
                for (int k = 0; k < N; k++) begin
                    if (slot(k) !== m_frame[k]) begin
                        $display("FAIL frame_data slot %0d actual=%0h required=%0h at %0t",
                                 k, slot(k), m_frame[k], $time);
                        break;
                    end
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            compare();
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic stream(input int n, input logic [W-1:0] base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.in_valid  = 1'b1;
            bus.in_sample = base + W'(i);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_done();
        @(negedge clk);
        bus.frame_done = 1'b1;
        @(negedge clk);
        bus.frame_done = 1'b0;
    endtask

    initial begin
        int p;
        logic [W-1:0] v;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sample = '0;
        bus.frame_done = 1'b0;
        idle(2);
        reset = 1'b0;
        chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
        chk("reset_frame_start", 64'(bus.frame_start), 64'd0);
        chk("reset_frame_count", 64'(bus.frame_count), 64'd0);

        // First frame 0..99, streamed continuously.
        p = start_pulses;
        stream(100, 32'd0);
        idle(3);
        chk("f1_pulses", 64'(start_pulses), 64'(p + 1));
        chk("f1_count", 64'(bus.frame_count), 64'd1);
        chk("f1_slot0", 64'(slot(0)), 64'd0);
        chk("f1_slot99", 64'(slot(99)), 64'd99);

        // Second bank fills while downstream is still busy.
        p = start_pulses;
        stream(100, 32'd100);
        idle(3);
        chk("f2_stall_ready", 64'(bus.in_ready), 64'd0);
        chk("f2_stall_pulses", 64'(start_pulses), 64'(p));
        pulse_done();
        idle(3);
        chk("f2_pulses", 64'(start_pulses), 64'(p + 1));
        chk("f2_count", 64'(bus.frame_count), 64'd2);
        chk("f2_slot0", 64'(slot(0)), 64'd100);
        chk("f2_slot99", 64'(slot(99)), 64'd199);
        chk("f2_ready", 64'(bus.in_ready), 64'd1);

        // frame_done while idle has no effect.
        pulse_done();
        idle(2);
        p = start_pulses;
        pulse_done();
        idle(3);
        chk("idle_done_pulses", 64'(start_pulses), 64'(p));
        chk("idle_done_count", 64'(bus.frame_count), 64'd2);

        // Extreme bit patterns pass through untouched.
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            v = W'(i * 3);
            if (i == 0)  v = 32'h7FFF_FFFF;
            if (i == 1)  v = 32'h8000_0000;
            if (i == 99) v = 32'hFFFF_FFFF;
            bus.in_valid  = 1'b1;
            bus.in_sample = v;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        idle(3);
        chk("raw_slot0", 64'(slot(0)), 64'h7FFF_FFFF);
        chk("raw_slot1", 64'(slot(1)), 64'h8000_0000);
        chk("raw_slot2", 64'(slot(2)), 64'd6);
        chk("raw_slot99", 64'(slot(99)), 64'hFFFF_FFFF);
        chk("raw_count", 64'(bus.frame_count), 64'd3);

        // Reset mid-fill discards the partial frame.
        pulse_done();
        stream(50, 32'd1000);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        p = start_pulses;
        stream(99, 32'd2000);
        idle(3);
        chk("rst_no_early_start", 64'(start_pulses), 64'(p));
        stream(1, 32'd2099);
        idle(3);
        chk("rst_pulses", 64'(start_pulses), 64'(p + 1));
        chk("rst_count", 64'(bus.frame_count), 64'd1);
        chk("rst_slot0", 64'(slot(0)), 64'd2000);
        chk("rst_slot49", 64'(slot(49)), 64'd2049);
        chk("rst_slot99", 64'(slot(99)), 64'd2099);

        // frame_count wraps from 0xFFFF to 0.
        pulse_done();
        @(negedge clk);
        force dut.frame_count_q = 16'hFFFF;
        m_count = 16'hFFFF;
        @(negedge clk);
        release dut.frame_count_q;
        idle(2);
        chk("wrap_preload", 64'(bus.frame_count), 64'hFFFF);
        stream(100, 32'd5000);
        idle(3);
        chk("wrap_count", 64'(bus.frame_count), 64'd0);
        chk("wrap_slot0", 64'(slot(0)), 64'd5000);

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/audio_frame_capture.md
AUDIO_FRAME_CAPTURE -- requirements
Module: audio_frame_capture

Interface
REQ-001 SHALL have parameters: N, 100, samples per frame; W, 32, sample width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  upstream sample strobe.
REQ-005 SHALL have port in_sample  input  W  signed two's-complement audio sample.
REQ-006 SHALL have port in_ready  output  1  block can accept a sample this cycle.
REQ-007 SHALL have port frame_start  output  1  one-cycle start pulse to the downstream min/max stage.
REQ-008 SHALL have port frame_done  input  1  done flag from the downstream stage.
REQ-009 SHALL have port frame_data  output  N*W  frozen frame; sample k at bits [k*W+W-1 : k*W].
REQ-010 SHALL have port frame_count  output  16  frames handed downstream, modulo 2^16.

Function
REQ-011 SHALL hold two N-entry banks (ping-pong), a write-bank select wb, and a write index wr_cnt in the range 0..N-1.
REQ-012 SHALL accept a sample on a rising edge when in_valid=1 and in_ready=1, write it to bank wb at index wr_cnt, and increment wr_cnt.
REQ-013 SHALL set the full flag on the edge that writes index N-1, and reset wr_cnt to 0 on that edge.
REQ-014 SHALL drive in_ready = !full combinationally; while full=1, in_valid is ignored and no sample is written.
REQ-015 SHALL keep a registered busy flag: 1 from handoff until frame_done is sampled high.
REQ-016 SHALL perform a handoff on the first edge where the write bank is complete (full=1, or index N-1 is written on this edge) and registered busy=0.
REQ-017 Handoff actions: read bank <= wb; wb <= !wb; full <= 0; busy <= 1; frame_count increments, wrapping 0xFFFF -> 0x0000.
REQ-018 SHALL register frame_start high for exactly the one cycle after the handoff edge, and low at all other times.
REQ-019 SHALL drive frame_data from the read bank, with the value stable from frame_start until the next handoff.
REQ-020 SHALL NOT write to the read bank while busy=1.
REQ-021 SHALL clear busy on the edge where frame_done=1 and busy=1; a handoff can occur no earlier than the following edge.
REQ-022 SHALL ignore frame_done while busy=0.
REQ-023 SHALL allow back-to-back frames with in_ready held high continuously when busy clears before the write bank completes.
REQ-024 SHALL treat in_sample as a raw bit pattern, with no arithmetic, saturation or reordering.

Reset
REQ-025 On reset=1 at an edge: wr_cnt=0, wb=0, full=0, busy=0, frame_start=0, frame_count=0; in_ready=1 in the following cycle.
REQ-026 Reset SHALL take priority over every other event, including accept, handoff and frame_done.
REQ-027 Reset mid-fill SHALL discard the partial frame; reset while busy SHALL abandon the handed-off frame.
REQ-028 Bank contents SHALL NOT be reset; frame_data is don't-care until the first frame_start.

Verification
REQ-029 Reset, then stream samples 0..99 with in_valid held high -> frame_start pulses once, one cycle after the edge accepting sample 99; frame_data[k]=k; frame_count=1; in_ready never drops.
REQ-030 Hold frame_done=0 and stream 200 samples -> second bank fills; in_ready goes low after sample 199; raise frame_done for 1 cycle -> busy clears, handoff on the next edge, frame_start pulses, frame_data[k]=100+k, in_ready returns high.
REQ-031 Feed values 0x7FFFFFFF, 0x80000000, -1 at indices 0, 1, 99 -> same bit patterns appear at those frame_data slots.
REQ-032 Assert reset after 50 accepted samples, then stream 100 more -> no frame_start before the 100th post-reset sample; frame_data holds only post-reset values; frame_count=1.
REQ-033 Pulse frame_done while idle (busy=0) -> no state change and no frame_start.
REQ-034 Preload frame_count=0xFFFF through 65535 handoffs (or force), then one more frame -> frame_count=0x0000.
